bit_serializer: RTL and testbench

//   Parallel-in / serial-out stage feeding the serial input (A) of the 1101

---
 rtl/bit_serializer.sv | 98 +++++++++
 tb/tb_bit_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-in / serial-out stage feeding the 1101 detector input. Words are
// taken over valid/ready and shifted out one bit per HOLD clocks, with no gap between words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int HOLD      = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             ser_last
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  // The bit on ser_bit is held in its own register, so only the bits still
  // waiting to go out need storage here.
  logic [WIDTH-2:0] rest;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             bit_done;
  logic             word_done;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-2:0] first_rest;
  logic             next_bit;
  logic [WIDTH-2:0] next_rest;

  assign bit_done  = (hold_cnt == HOLD_MAX);
  assign word_done = (state == SHIFT) && bit_done && (bit_cnt == BIT_MAX);
  // NOTE: in_ready is combinational so a new word can be taken on the final
  // clock of the current one; gating with reset keeps it low during reset.
  assign in_ready  = !reset && ((state == IDLE) || word_done);
  assign accept    = in_valid && in_ready;

  assign first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign first_rest = MSB_FIRST ? in_data[WIDTH-2:0] : in_data[WIDTH-1:1];
  assign next_bit   = MSB_FIRST ? rest[WIDTH-2] : rest[0];
  assign next_rest  = MSB_FIRST ? (rest << 1) : (rest >> 1);

  // NOTE: all state uses nonblocking assignments so every register samples
  // the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rest        <= '0;
      bit_cnt     <= '0;
      hold_cnt    <= '0;
      ser_bit     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      ser_last    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (accept) begin
        state       <= SHIFT;
        rest        <= first_rest;
        bit_cnt     <= '0;
        hold_cnt    <= '0;
        ser_bit     <= first_bit;
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        ser_last    <= 1'b0;
      end else if (state == SHIFT) begin
        if (!bit_done) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (bit_cnt == BIT_MAX) begin
          state     <= IDLE;
          bit_cnt   <= '0;
          hold_cnt  <= '0;
          ser_bit   <= IDLE_BIT;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end else begin
          hold_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
          rest     <= next_rest;
          ser_bit  <= next_bit;
          ser_last <= (bit_cnt == BIT_PEN);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations (HOLD=1 MSB, HOLD=3 MSB,
// HOLD=1 LSB with idle level 1) checked against directed vectors and a queue-based model.
module tb_bit_serializer;

  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data     [N];
  logic         in_valid    [N];
  logic         in_ready    [N];
  logic         ser_bit     [N];
  logic         ser_valid   [N];
  logic         frame_start [N];
  logic         ser_last    [N];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .HOLD(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_base (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]),
    .frame_start(frame_start[0]), .ser_last(ser_last[0]));

  bit_serializer #(.WIDTH(W), .HOLD(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_hold3 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]),
    .frame_start(frame_start[1]), .ser_last(ser_last[1]));

  bit_serializer #(.WIDTH(W), .HOLD(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]),
    .frame_start(frame_start[2]), .ser_last(ser_last[2]));

  function automatic int hold_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 2);
  endfunction

  function automatic logic idle_of(input int k);
    return (k == 2) ? 1'b1 : 1'b0;
  endfunction

  // One expected output clock of a word.
  typedef struct packed {
    logic b;
    logic v;
    logic fs;
    logic last;
  } exp_t;

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         b;
    logic         v;
    logic         fs;
    logic         last;
    logic         ready;
  } vec_t;

  exp_t q   [N][$];
  exp_t cur [N];
  bit   armed = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic s_bit [N], s_valid [N], s_fs [N], s_last [N], s_ready [N];

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: an accepted word expands into WIDTH*HOLD future output clocks;
  // the block is ready exactly when nothing of the current word is still queued.
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        q[k].delete();
        cur[k] = '0;
      end else begin
        if (armed && in_valid[k] && q[k].size() == 0) begin
          for (int b = 0; b < W; b++) begin
            for (int h = 0; h < hold_of(k); h++) begin
              exp_t e;
              e.b    = msb_of(k) ? in_data[k][W-1-b] : in_data[k][b];
              e.v    = 1'b1;
              e.fs   = (b == 0 && h == 0);
              e.last = (b == W - 1);
              q[k].push_back(e);
            end
          end
        end
        cur[k] = (q[k].size() > 0) ? q[k].pop_front() : '0;
      end
    end
    if (reset) armed = 1'b1;
  endtask

  // Samples this cycle's outputs, checks them against the model, then clocks.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      s_bit[k]   = ser_bit[k];
      s_valid[k] = ser_valid[k];
      s_fs[k]    = frame_start[k];
      s_last[k]  = ser_last[k];
      s_ready[k] = in_ready[k];
      if (armed) begin
        check($sformatf("model%0d ser_bit", k), s_bit[k], cur[k].v ? cur[k].b : idle_of(k));
        check($sformatf("model%0d ser_valid", k), s_valid[k], cur[k].v);
        check($sformatf("model%0d frame_start", k), s_fs[k], cur[k].fs);
        check($sformatf("model%0d ser_last", k), s_last[k], cur[k].last);
        check($sformatf("model%0d in_ready", k), s_ready[k], !reset && q[k].size() == 0);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_idle(input string tag, input int k);
    check({tag, " idle ser_bit"}, s_bit[k], idle_of(k));
    check({tag, " idle ser_valid"}, s_valid[k], 1'b0);
    check({tag, " idle frame_start"}, s_fs[k], 1'b0);
    check({tag, " idle ser_last"}, s_last[k], 1'b0);
  endtask

  vec_t         t1 [10];
  logic [W-1:0] pat;
  logic [15:0]  pat16;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = '0;
    end

    // Reset state
    cycle();
    cycle();
    check("reset in_ready low", s_ready[0], 1'b0);
    reset = 1'b0;
    cycle();
    for (int k = 0; k < N; k++) begin
      expect_idle($sformatf("reset%0d", k), k);
      check($sformatf("reset%0d in_ready", k), s_ready[k], 1'b1);
    end

    // Single word 8'hD0, MSB first, HOLD=1
    pat = 8'hD0;
    t1[0] = '{1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++)
      t1[i] = '{1'b0, 8'h00, pat[8-i], 1'b1, (i == 1), (i == 8), (i == 8)};
    t1[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = t1[i].valid;
      in_data[0]  = t1[i].data;
      cycle();
      check($sformatf("t1[%0d] ser_bit", i), s_bit[0], t1[i].b);
      check($sformatf("t1[%0d] ser_valid", i), s_valid[0], t1[i].v);
      check($sformatf("t1[%0d] frame_start", i), s_fs[0], t1[i].fs);
      check($sformatf("t1[%0d] ser_last", i), s_last[0], t1[i].last);
      check($sformatf("t1[%0d] in_ready", i), s_ready[0], t1[i].ready);
    end

    // Back-to-back 8'h0D then 8'hA0 with in_valid held
    pat16 = 16'h0DA0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h0D;
    cycle();
    in_data[0] = 8'hA0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i == 7) in_valid[0] = 1'b0;
      check($sformatf("b2b[%0d] ser_bit", i), s_bit[0], pat16[15-i]);
      check($sformatf("b2b[%0d] ser_valid", i), s_valid[0], 1'b1);
      check($sformatf("b2b[%0d] frame_start", i), s_fs[0], (i == 0 || i == 8));
    end
    cycle();
    expect_idle("b2b end", 0);

    // HOLD=3, 8'hB0
    pat = 8'hB0;
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hB0;
    cycle();
    in_valid[1] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      check($sformatf("hold3[%0d] ser_bit", i), s_bit[1], pat[7 - i / 3]);
      check($sformatf("hold3[%0d] ser_valid", i), s_valid[1], 1'b1);
      check($sformatf("hold3[%0d] ser_last", i), s_last[1], (i >= 21));
      check($sformatf("hold3[%0d] in_ready", i), s_ready[1], (i == 23));
    end
    cycle();
    expect_idle("hold3 end", 1);
    check("hold3 end in_ready", s_ready[1], 1'b1);

    // LSB first, 8'h0B, idle level 1
    pat = 8'b1101_0000;
    in_valid[2] = 1'b1;
    in_data[2]  = 8'h0B;
    cycle();
    expect_idle("lsb pre", 2);
    in_valid[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("lsb[%0d] ser_bit", i), s_bit[2], pat[7-i]);
      check($sformatf("lsb[%0d] frame_start", i), s_fs[2], (i == 0));
    end
    cycle();
    expect_idle("lsb end", 2);

    // Reset after the third bit of 8'hFF, then a full new word
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hFF;
    cycle();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    cycle();
    check("rst-mid in_ready during reset", s_ready[0], 1'b0);
    reset = 1'b0;
    cycle();
    expect_idle("rst-mid", 0);
    check("rst-mid in_ready after", s_ready[0], 1'b1);
    pat = 8'hA5;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    cycle();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("rst-new[%0d] ser_bit", i), s_bit[0], pat[7-i]);
      check($sformatf("rst-new[%0d] ser_valid", i), s_valid[0], 1'b1);
    end
    cycle();
    expect_idle("rst-new end", 0);

    // in_valid pulsed mid-word is ignored
    pat = 8'h96;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h96;
    cycle();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h55;
      end
      cycle();
      in_valid[0] = 1'b0;
      check($sformatf("ign[%0d] ser_bit", i), s_bit[0], pat[7-i]);
      check($sformatf("ign[%0d] frame_start", i), s_fs[0], (i == 0));
    end
    cycle();
    expect_idle("ign end", 0);
    cycle();
    expect_idle("ign end+1", 0);

    // Random traffic and occasional resets, checked by the model
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < N; k++) begin
        in_valid[k] = ($urandom_range(0, 9) < 6);
        in_data[k]  = W'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    for (int k = 0; k < N; k++) in_valid[k] = 1'b0;
    for (int n = 0; n < 30; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
